// File: rtl/qlf_dsp_fir_reader.sv
// rtl/qlf_dsp_fir_reader.sv - FIR frame sequencer driving a DSP accumulator, capturing results into an output FIFO.
// Define QLF_DSP_FIR_READER_SAT_EN to saturate captured samples instead of truncating them.
module qlf_dsp_fir_reader #(
    parameter int NTAPS      = 4,
    parameter int OUT_W      = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clock_i,
    input  logic                            reset_n,
    input  logic                            start_i,
    input  logic                            stop_i,
    input  logic                            clear_i,
    input  logic [37:0]                     z_i,
    output logic                            feedback_o,
    output logic [$clog2(NTAPS+1)-1:0]      tap_o,
    output logic                            busy_o,
    output logic [OUT_W-1:0]                data_o,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic [$clog2(FIFO_DEPTH):0]     level_o,
    output logic                            overflow_o
);
    localparam int TW = $clog2(NTAPS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [TW-1:0] LAST_TAP = TW'(NTAPS);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   cnt_q;
    logic            stop_q;

    logic [OUT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    count;
    logic             empty, full, pop, push_ok, drop;
    logic [OUT_W-1:0] sample;

    assign feedback_o = (state_q == RUN) && (cnt_q == LAST_TAP);
    assign tap_o      = (state_q == RUN) ? cnt_q : '0;
    assign busy_o     = (state_q == RUN);

`ifdef QLF_DSP_FIR_READER_SAT_EN
    localparam logic signed [37:0] SAT_MAX = {{(39-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [37:0] SAT_MIN = ~SAT_MAX;
    logic signed [37:0] zs;
    assign zs = z_i;
    always_comb begin
        sample = zs[OUT_W-1:0];
        if (zs > SAT_MAX)
            sample = SAT_MAX[OUT_W-1:0];
        else if (zs < SAT_MIN)
            sample = SAT_MIN[OUT_W-1:0];
    end
`else
    // Upper accumulator bits are intentionally discarded (wrapping truncation).
    logic unused_z_hi;
    assign unused_z_hi = ^z_i;
    assign sample = z_i[OUT_W-1:0];
`endif

    always_ff @(posedge clock_i or negedge reset_n) begin
        if (!reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // A stop request arriving on the capture cycle itself also ends the run there.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_i) state_d = RUN;
            RUN:  if (feedback_o && (stop_q || stop_i)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            stop_q <= 1'b0;
        end else if (state_q != RUN || state_d != RUN) begin
            cnt_q  <= '0;
            stop_q <= 1'b0;
        end else begin
            cnt_q <= (cnt_q == LAST_TAP) ? '0 : cnt_q + 1'b1;
            if (stop_i)
                stop_q <= 1'b1;
        end
    end

    assign empty   = (count == '0);
    assign full    = (count == FULL_LVL);
    assign pop     = !empty && ready_i;
    assign push_ok = feedback_o && (!full || pop);
    assign drop    = feedback_o && full && !pop;

    always_ff @(posedge clock_i) begin
        if (push_ok)
            mem[wr_ptr] <= sample;
    end

    always_ff @(posedge clock_i or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)
                count <= count + 1'b1;
            else if (!push_ok && pop)
                count <= count - 1'b1;
            // A drop in the same cycle as a clear wins, so no event is lost.
            if (drop)
                overflow_o <= 1'b1;
            else if (clear_i)
                overflow_o <= 1'b0;
        end
    end

    assign valid_o = !empty;
    assign level_o = count;
    assign data_o  = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_qlf_dsp_fir_reader.sv
// tb/tb_qlf_dsp_fir_reader.sv - directed self-checking bench for qlf_dsp_fir_reader.
module tb_qlf_dsp_fir_reader;
    logic        clk = 1'b0;
    logic        reset_n, start_i, stop_i, clear_i, ready_i;
    logic [37:0] z_i;
    logic        feedback_o, busy_o, valid_o, overflow_o;
    logic [2:0]  tap_o;
    logic [19:0] data_o;
    logic [2:0]  level_o;

    int n_vec = 0;
    int n_err = 0;

    qlf_dsp_fir_reader dut (
        .clock_i(clk), .reset_n(reset_n), .start_i(start_i), .stop_i(stop_i),
        .clear_i(clear_i), .z_i(z_i), .feedback_o(feedback_o), .tap_o(tap_o),
        .busy_o(busy_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .level_o(level_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [37:0] z;
        logic [19:0] exp;
    } vec_t;
    vec_t vt [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [37:0] z, input logic rdy);
        int   k;
        logic old_rdy;
        k = 0;
        while (feedback_o !== 1'b1 && k < 12) begin
            step();
            k++;
        end
        chk("fb_wait", {63'd0, feedback_o}, 64'd1);
        old_rdy = ready_i;
        z_i     = z;
        ready_i = rdy;
        step();
        ready_i = old_rdy;
    endtask

    initial begin
        vt[0] = '{38'h36, 20'h00036};
`ifdef QLF_DSP_FIR_READER_SAT_EN
        vt[1] = '{38'h0000100000, 20'h7FFFF};
        vt[2] = '{38'h3FFFEFFFFF, 20'h80000};
        vt[5] = '{38'h12345ABCDE, 20'h7FFFF};
`else
        vt[1] = '{38'h0000100000, 20'h00000};
        vt[2] = '{38'h3FFFEFFFFF, 20'hFFFFF};
        vt[5] = '{38'h12345ABCDE, 20'hABCDE};
`endif
        vt[3] = '{38'h3FFFFFFFFB, 20'hFFFFB};
        vt[4] = '{38'h000007FFFF, 20'h7FFFF};

        reset_n = 1'b0; start_i = 1'b0; stop_i = 1'b0; clear_i = 1'b0;
        ready_i = 1'b1; z_i = '0;
        #3;
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_valid", {63'd0, valid_o}, 64'd0);
        chk("rst_level", {61'd0, level_o}, 64'd0);
        chk("rst_data", {44'd0, data_o}, 64'd0);
        chk("rst_fb", {63'd0, feedback_o}, 64'd0);
        chk("rst_tap", {61'd0, tap_o}, 64'd0);
        chk("rst_ovf", {63'd0, overflow_o}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        step();
        chk("post_rst_idle", {63'd0, busy_o}, 64'd0);

        // single frame per vector, stop requested at tap 0, sample passes straight through
        for (int i = 0; i < 6; i++) begin
            start_i = 1'b1;
            step();
            start_i = 1'b0;
            stop_i  = 1'b1;
            for (int c = 0; c < 5; c++) begin
                chk("frame_tap", {61'd0, tap_o}, 64'(c));
                chk("frame_fb", {63'd0, feedback_o}, (c == 4) ? 64'd1 : 64'd0);
                if (c == 4) z_i = vt[i].z;
                step();
                stop_i = 1'b0;
            end
            chk("vec_valid", {63'd0, valid_o}, 64'd1);
            chk("vec_data", {44'd0, data_o}, {44'd0, vt[i].exp});
            chk("vec_busy", {63'd0, busy_o}, 64'd0);
            chk("vec_level", {61'd0, level_o}, 64'd1);
            step();
            chk("vec_popped", {63'd0, valid_o}, 64'd0);
        end

        // overflow: five frames into a four-entry FIFO with no consumer
        ready_i = 1'b0;
        start_i = 1'b1; step(); start_i = 1'b0;
        for (int f = 1; f <= 4; f++) begin
            capture(38'h100 + 38'(f), 1'b0);
            chk("ovf_hold_data", {44'd0, data_o}, 64'h101);
        end
        chk("ovf_level4", {61'd0, level_o}, 64'd4);
        chk("ovf_not_yet", {63'd0, overflow_o}, 64'd0);
        stop_i = 1'b1; step(); stop_i = 1'b0;
        capture(38'h105, 1'b0);
        chk("ovf_level", {61'd0, level_o}, 64'd4);
        chk("ovf_set", {63'd0, overflow_o}, 64'd1);
        chk("ovf_busy", {63'd0, busy_o}, 64'd0);
        ready_i = 1'b1;
        for (int f = 1; f <= 4; f++) begin
            chk("ovf_drain_valid", {63'd0, valid_o}, 64'd1);
            chk("ovf_drain_data", {44'd0, data_o}, 64'h100 + 64'(f));
            step();
        end
        chk("ovf_5th_absent", {63'd0, valid_o}, 64'd0);
        chk("ovf_sticky", {63'd0, overflow_o}, 64'd1);
        clear_i = 1'b1; step(); clear_i = 1'b0;
        chk("ovf_cleared", {63'd0, overflow_o}, 64'd0);

        // full FIFO with a pop on the capture edge: no drop, order kept
        ready_i = 1'b0;
        start_i = 1'b1; step(); start_i = 1'b0;
        for (int f = 1; f <= 4; f++) capture(38'h200 + 38'(f), 1'b0);
        stop_i = 1'b1; step(); stop_i = 1'b0;
        capture(38'h205, 1'b1);
        chk("full_pp_level", {61'd0, level_o}, 64'd4);
        chk("full_pp_ovf", {63'd0, overflow_o}, 64'd0);
        ready_i = 1'b1;
        for (int f = 2; f <= 5; f++) begin
            chk("full_pp_data", {44'd0, data_o}, 64'h200 + 64'(f));
            step();
        end
        chk("full_pp_empty", {63'd0, valid_o}, 64'd0);

        // stop at tap 1, then reset mid-frame with two queued samples
        start_i = 1'b1; step(); start_i = 1'b0;
        chk("stop_tap0", {61'd0, tap_o}, 64'd0);
        step();
        chk("stop_tap1", {61'd0, tap_o}, 64'd1);
        stop_i = 1'b1; step(); stop_i = 1'b0;
        capture(38'h301, 1'b1);
        chk("stop_busy", {63'd0, busy_o}, 64'd0);
        chk("stop_fb", {63'd0, feedback_o}, 64'd0);
        chk("stop_data", {44'd0, data_o}, 64'h301);
        step();
        for (int c = 0; c < 6; c++) begin
            chk("stop_stays_idle", {62'd0, busy_o, feedback_o}, 64'd0);
            step();
        end

        ready_i = 1'b0;
        start_i = 1'b1; step(); start_i = 1'b0;
        capture(38'h302, 1'b0);
        capture(38'h303, 1'b0);
        step(); step();
        chk("mid_tap2", {61'd0, tap_o}, 64'd2);
        chk("mid_level2", {61'd0, level_o}, 64'd2);
        reset_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, valid_o}, 64'd0);
        chk("arst_level", {61'd0, level_o}, 64'd0);
        chk("arst_busy", {63'd0, busy_o}, 64'd0);
        chk("arst_tap", {61'd0, tap_o}, 64'd0);
        chk("arst_data", {44'd0, data_o}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ready_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            chk("no_capture_after_rst", {62'd0, busy_o, valid_o}, 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
